neuron_o_backprop: RTL and testbench

Backward-pass companion to the output neuron. Given the forward inputs `a_1`/`a_2`, the tanh output `y` and a training target, it computes the output delta `(y - target)·(1 - y²)`. It then applies an SGD update to the weights `w_1`, `w_2` and bias `b`, which it holds in registers and presents to the forward neuron. The registered delta is exported for hidden-layer backprop. One shared signed multiplier is sequenced by an FSM.

---
 rtl/neuron_o_backprop.sv | 206 ++++++++++++++++++++
 tb/tb_neuron_o_backprop.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_o_backprop.sv
// -----------------------------------------------------------------------------
// neuron_o_backprop
//
// Backward pass and SGD update for the tanh output neuron. One training step
// computes
//   e     = sat(y - target)
//   dact  = sat(ONE - fmul(y, y))
//   delta = fmul(e, dact)
//   ld    = fmul(lr, delta)
//   w_1  <= sat(w_1 - fmul(ld, a_1))
//   w_2  <= sat(w_2 - fmul(ld, a_2))
//   b    <= sat(b - ld)
// A single saturating signed fixed-point multiplier is time-shared, and an FSM
// sequences it. All arithmetic is signed Q(WIDTH-FRAC).FRAC and saturates.
//
// Step schedule, where start is accepted at edge k:
//   k+1 SQ    : y*y and e
//   k+2 DEL_A : dact
//   k+3 DEL_B : delta
//   k+4 LRD   : ld
//   k+5 G1    : w_1
//   k+6 G2    : w_2, b, done pulse raised, busy dropped
// The done cycle (k+6..k+7) is spent in IDLE, so the next start is accepted
// at edge k+7.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request a training step (IDLE only)
//   a_1, a_2, y, target, lr step operands, latched when start is accepted
//   load                    load w_1_in/w_2_in/b_in (IDLE only, wins over start)
//   w_1_in, w_2_in, b_in    parameter load values
//   w_1, w_2, b             registered parameters
//   delta                   registered output delta of the last step
//   busy                    high while a step is in progress
//   done                    one-cycle pulse when the update completes
// -----------------------------------------------------------------------------
module neuron_o_backprop #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a_1,
    input  logic signed [WIDTH-1:0] a_2,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] target,
    input  logic signed [WIDTH-1:0] lr,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] w_1_in,
    input  logic signed [WIDTH-1:0] w_2_in,
    input  logic signed [WIDTH-1:0] b_in,
    output logic signed [WIDTH-1:0] w_1,
    output logic signed [WIDTH-1:0] w_2,
    output logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] delta,
    output logic                    busy,
    output logic                    done
);

    localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        DEL_A,
        DEL_B,
        LRD,
        G1,
        G2
    } state_t;

    state_t state, next_state;

    // Latched step operands and intermediate results.
    logic signed [WIDTH-1:0] a1_q, a2_q, y_q, tgt_q, lr_q;
    logic signed [WIDTH-1:0] e_q, sq_q, dact_q, ld_q;

    // Shared multiplier operands and result.
    logic signed [WIDTH-1:0] op_a, op_b, prod;

    // x - z with one guard bit; clamp when the guard and sign bits disagree.
    function automatic logic signed [WIDTH-1:0] sat_sub(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] z
    );
        logic signed [WIDTH:0] d;
        d = {x[WIDTH-1], x} - {z[WIDTH-1], z};
        if (d[WIDTH] != d[WIDTH-1])
            sat_sub = d[WIDTH] ? SAT_MIN : SAT_MAX;
        else
            sat_sub = d[WIDTH-1:0];
    endfunction

    // Full-width signed product, arithmetic shift by FRAC, then clamp. The
    // result fits when the bits above the kept sign bit all equal it.
    function automatic logic signed [WIDTH-1:0] fmul(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] z
    );
        logic signed [2*WIDTH-1:0] xe, ze, p;
        xe = {{WIDTH{x[WIDTH-1]}}, x};
        ze = {{WIDTH{z[WIDTH-1]}}, z};
        p  = (xe * ze) >>> FRAC;
        if ((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]))
            fmul = p[WIDTH-1:0];
        else
            fmul = p[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
    endfunction

    // Operand selection for the shared multiplier.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            SQ:    begin op_a = y_q;  op_b = y_q;    end
            DEL_B: begin op_a = e_q;  op_b = dact_q; end
            LRD:   begin op_a = lr_q; op_b = delta;  end
            G1:    begin op_a = ld_q; op_b = a1_q;   end
            G2:    begin op_a = ld_q; op_b = a2_q;   end
            default: ;
        endcase
    end

    assign prod = fmul(op_a, op_b);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; load has priority over start in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!load && start) next_state = SQ;
            SQ:      next_state = DEL_A;
            DEL_A:   next_state = DEL_B;
            DEL_B:   next_state = LRD;
            LRD:     next_state = G1;
            G1:      next_state = G2;
            G2:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath. The internal registers are reset too, so a step cut short by
    // reset leaves no trace anywhere in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_1    <= '0;
            w_2    <= '0;
            b      <= '0;
            delta  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a1_q   <= '0;
            a2_q   <= '0;
            y_q    <= '0;
            tgt_q  <= '0;
            lr_q   <= '0;
            e_q    <= '0;
            sq_q   <= '0;
            dact_q <= '0;
            ld_q   <= '0;
        end else begin
            // busy rises one edge after acceptance and falls with the final update.
            busy <= (state != IDLE) && (state != G2);
            done <= (state == G2);
            case (state)
                IDLE: begin
                    if (load) begin
                        w_1 <= w_1_in;
                        w_2 <= w_2_in;
                        b   <= b_in;
                    end else if (start) begin
                        a1_q  <= a_1;
                        a2_q  <= a_2;
                        y_q   <= y;
                        tgt_q <= target;
                        lr_q  <= lr;
                    end
                end
                SQ: begin
                    sq_q <= prod;
                    e_q  <= sat_sub(y_q, tgt_q);
                end
                DEL_A: dact_q <= sat_sub(ONE, sq_q);
                DEL_B: delta  <= prod;
                LRD:   ld_q   <= prod;
                G1:    w_1    <= sat_sub(w_1, prod);
                G2: begin
                    w_2 <= sat_sub(w_2, prod);
                    b   <= sat_sub(b, ld_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_o_backprop.sv
// -----------------------------------------------------------------------------
// tb_neuron_o_backprop
//
// Directed bench for neuron_o_backprop. Expected values are hand-computed
// Q16.16 results. Outputs are sampled 1 time unit after each rising edge, and
// inputs are driven at the same point so the next edge sees them. The bench
// tracks the parameters and delta it expects the DUT to hold (cur_*), so it
// can check that nothing changes before its scheduled edge.
// -----------------------------------------------------------------------------
module tb_neuron_o_backprop;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, load;
    logic [31:0] a_1, a_2, y, target, lr;
    logic [31:0] w_1_in, w_2_in, b_in;
    logic [31:0] w_1, w_2, b, delta;
    logic        busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] cur_w1, cur_w2, cur_b, cur_delta;

    always #5 clk = ~clk;

    neuron_o_backprop #(.WIDTH(32), .FRAC(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_1    (a_1),
        .a_2    (a_2),
        .y      (y),
        .target (target),
        .lr     (lr),
        .load   (load),
        .w_1_in (w_1_in),
        .w_2_in (w_2_in),
        .b_in   (b_in),
        .w_1    (w_1),
        .w_2    (w_2),
        .b      (b),
        .delta  (delta),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_params(input string tag, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] bb);
        w_1_in = w1; w_2_in = w2; b_in = bb;
        load = 1'b1;
        tick();
        load = 1'b0;
        cur_w1 = w1; cur_w2 = w2; cur_b = bb;
        check({tag, " w_1"}, w_1, w1);
        check({tag, " w_2"}, w_2, w2);
        check({tag, " b"},   b,   bb);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    // One step, with start accepted at edge k. The iteration i runs just after
    // edge k+i. With poke set, start and load are also asserted for edges k+2
    // and k+6, and they must have no effect.
    task automatic run_step(input string tag,
                            input logic [31:0] in_a1, input logic [31:0] in_a2,
                            input logic [31:0] in_y,  input logic [31:0] in_t,
                            input logic [31:0] in_lr,
                            input logic [31:0] exp_delta, input logic [31:0] exp_w1,
                            input logic [31:0] exp_w2,    input logic [31:0] exp_b,
                            input bit poke);
        a_1 = in_a1; a_2 = in_a2; y = in_y; target = in_t; lr = in_lr;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Changes after acceptance must not affect the step.
        a_1 = $urandom(); a_2 = $urandom(); y = $urandom(); target = $urandom(); lr = $urandom();
        for (int i = 0; i <= 6; i++) begin
            check($sformatf("%s busy@k+%0d", tag, i), 32'(busy), 32'(i >= 1 && i <= 5));
            check($sformatf("%s done@k+%0d", tag, i), 32'(done), 32'(i == 6));
            if (poke && (i == 1 || i == 5)) begin
                start = 1'b1; load = 1'b1;
                w_1_in = 32'h1234_5678; w_2_in = 32'h0BAD_F00D; b_in = 32'h7777_0000;
            end else begin
                start = 1'b0; load = 1'b0;
            end
            if (i == 2) check({tag, " delta early"}, delta, cur_delta);
            if (i == 3) check({tag, " delta"}, delta, exp_delta);
            if (i == 4) check({tag, " w_1 early"}, w_1, cur_w1);
            if (i == 5) begin
                check({tag, " w_1"}, w_1, exp_w1);
                check({tag, " w_2 early"}, w_2, cur_w2);
                check({tag, " b early"}, b, cur_b);
            end
            if (i == 6) begin
                check({tag, " w_2"}, w_2, exp_w2);
                check({tag, " b"}, b, exp_b);
            end
            if (i < 6) tick();
        end
        cur_w1 = exp_w1; cur_w2 = exp_w2; cur_b = exp_b; cur_delta = exp_delta;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; load = 1'b0;
        a_1 = '0; a_2 = '0; y = '0; target = '0; lr = '0;
        w_1_in = '0; w_2_in = '0; b_in = '0;
        cur_w1 = '0; cur_w2 = '0; cur_b = '0; cur_delta = '0;
        #12;
        check("reset w_1",   w_1,   32'h0);
        check("reset w_2",   w_2,   32'h0);
        check("reset b",     b,     32'h0);
        check("reset delta", delta, 32'h0);
        check("reset busy",  32'(busy), 32'd0);
        check("reset done",  32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal step, followed by the zero-error step accepted at k+7.
        load_params("nom load", 32'h0000_8000, 32'hFFFF_C000, 32'h0000_0000);
        run_step("nominal", 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'h0000_8000,
                 32'h0000_6000, 32'h0000_5000, 32'hFFFF_A800, 32'hFFFF_D000, 1'b0);
        run_step("zero err", 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_4000, 32'h0000_8000,
                 32'h0000_0000, 32'h0000_5000, 32'hFFFF_A800, 32'hFFFF_D000, 1'b0);
        tick();
        check("zero err done after", 32'(done), 32'd0);

        // Saturation: w_1 clamps at the positive limit.
        load_params("sat load", 32'h7FFF_F000, 32'h0000_0000, 32'h0000_0000);
        run_step("sat", 32'h0001_0000, 32'h0000_0000, 32'hFFFF_8000, 32'h0000_8000, 32'h0001_0000,
                 32'hFFFF_4000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_C000, 1'b0);
        tick();

        // Collision: load wins and start is dropped.
        a_1 = 32'h0001_0000; a_2 = 32'h0000_8000; y = 32'h0000_8000; target = '0; lr = 32'h0000_8000;
        w_1_in = 32'h1111_0000; w_2_in = 32'h2222_0000; b_in = 32'h3333_0000;
        start = 1'b1; load = 1'b1;
        tick();
        start = 1'b0; load = 1'b0;
        cur_w1 = 32'h1111_0000; cur_w2 = 32'h2222_0000; cur_b = 32'h3333_0000;
        check("collide w_1", w_1, 32'h1111_0000);
        check("collide w_2", w_2, 32'h2222_0000);
        check("collide b",   b,   32'h3333_0000);
        tick();
        check("collide busy", 32'(busy), 32'd0);
        tick();
        check("collide busy2", 32'(busy), 32'd0);
        check("collide done",  32'(done), 32'd0);

        // Requests made mid-step are ignored.
        load_params("poke load", 32'h0000_8000, 32'hFFFF_C000, 32'h0000_0000);
        run_step("poke", 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'h0000_8000,
                 32'h0000_6000, 32'h0000_5000, 32'hFFFF_A800, 32'hFFFF_D000, 1'b1);
        tick();
        check("poke done after", 32'(done), 32'd0);
        check("poke busy after", 32'(busy), 32'd0);

        // Asynchronous reset between edges k+4 and k+5.
        load_params("rst load", 32'h0000_8000, 32'hFFFF_C000, 32'h0000_0000);
        a_1 = 32'h0001_0000; a_2 = 32'h0000_8000; y = 32'h0000_8000; target = '0; lr = 32'h0000_8000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst w_1",   w_1,   32'h0);
        check("midrst w_2",   w_2,   32'h0);
        check("midrst b",     b,     32'h0);
        check("midrst delta", delta, 32'h0);
        check("midrst busy",  32'(busy), 32'd0);
        check("midrst done",  32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        cur_w1 = '0; cur_w2 = '0; cur_b = '0; cur_delta = '0;
        tick();
        tick();
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst done", 32'(done), 32'd0);
        check("post rst w_1",  w_1, 32'h0);
        load_params("rerun load", 32'h0000_8000, 32'hFFFF_C000, 32'h0000_0000);
        run_step("rerun", 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'h0000_8000,
                 32'h0000_6000, 32'h0000_5000, 32'hFFFF_A800, 32'hFFFF_D000, 1'b0);
        tick();
        check("rerun done after", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
